// File: rtl/lfsr_rng_if.sv
// Sample handshake between the LFSR random source and its consumer.
// The producer drives rnd/rnd_valid; the consumer answers with rnd_ready.
interface lfsr_rng_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] rnd;
    logic             rnd_valid;
    logic             rnd_ready;

    modport master (
        output rnd,
        output rnd_valid,
        input  rnd_ready
    );

    modport slave (
        input  rnd,
        input  rnd_valid,
        output rnd_ready
    );
endinterface

// File: rtl/lfsr_rng.sv
// Fibonacci shift-left LFSR that publishes one sample every SHIFTS shifts
// through a registered valid/ready output stage with a sticky overrun flag.
module lfsr_rng #(
    parameter int               WIDTH  = 16,
    parameter logic [WIDTH-1:0] TAPS   = 16'hB400,
    parameter logic [WIDTH-1:0] SEED   = 1,
    parameter int               SHIFTS = 13
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] lfsr_state,
    output logic             overrun,
    lfsr_rng_if.master       rndIf
);
    localparam int               CNT_W    = $clog2(SHIFTS + 1);
    localparam logic [WIDTH-1:0] EFF_SEED = (SEED == '0) ? WIDTH'(1) : SEED;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHIFTS - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } fsm_t;

    logic [WIDTH-1:0] stateQ, stateD;
    logic [CNT_W-1:0] countQ, countD;
    logic [WIDTH-1:0] rndQ, rndD;
    logic             overrunQ, overrunD;
    fsm_t             fsmQ, fsmD;

    logic             feedback;
    logic [WIDTH-1:0] shifted;
    logic             sampleEvt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateQ   <= EFF_SEED;
            countQ   <= '0;
            rndQ     <= '0;
            overrunQ <= 1'b0;
            fsmQ     <= EMPTY;
        end else begin
            stateQ   <= stateD;
            countQ   <= countD;
            rndQ     <= rndD;
            overrunQ <= overrunD;
            fsmQ     <= fsmD;
        end
    end

    // A tap mask without the MSB could collapse the register to zero; fall
    // back to the seed so the all-zero lock-up state can never be entered.
    always_comb begin
        feedback  = ^(stateQ & TAPS);
        shifted   = {stateQ[WIDTH-2:0], feedback};
        if (shifted == '0) begin
            shifted = EFF_SEED;
        end

        stateD    = stateQ;
        countD    = countQ;
        sampleEvt = 1'b0;
        if (seed_load) begin
            stateD = (seed_in == '0) ? EFF_SEED : seed_in;
            countD = '0;
        end else if (enable) begin
            stateD = shifted;
            if (countQ == LAST_CNT) begin
                countD    = '0;
                sampleEvt = 1'b1;
            end else begin
                countD = countQ + CNT_W'(1);
            end
        end
    end

    // A fresh sample replaces the held one only if the old one is consumed
    // in the same cycle; otherwise it is dropped and overrun latches.
    always_comb begin
        fsmD     = fsmQ;
        rndD     = rndQ;
        overrunD = overrunQ;
        case (fsmQ)
            EMPTY: begin
                if (sampleEvt) begin
                    fsmD = FULL;
                    rndD = shifted;
                end
            end
            FULL: begin
                if (sampleEvt) begin
                    if (rndIf.rnd_ready) begin
                        rndD = shifted;
                    end else begin
                        overrunD = 1'b1;
                    end
                end else if (rndIf.rnd_ready) begin
                    fsmD = EMPTY;
                end
            end
            default: begin
                fsmD = EMPTY;
            end
        endcase
    end

    assign lfsr_state      = stateQ;
    assign overrun         = overrunQ;
    assign rndIf.rnd       = rndQ;
    assign rndIf.rnd_valid = (fsmQ == FULL);
endmodule
